// File: rtl/current_sense_frontend_pkg.sv
// current_sense_frontend_pkg: shared Q8.8 constants, ADC constants, frame states and saturation helper
package current_sense_frontend_pkg;
  localparam int Q_W = 16;
  localparam logic [Q_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [Q_W-1:0] Q_MIN = 16'h8000;
  localparam logic [11:0] ADC_MID = 12'd2048;
  localparam int CAL_SAMPLES = 16;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CALC} adc_state_e;
  typedef struct packed {
    logic ovr;
    logic [Q_W-1:0] val;
  } sat_t;
  function automatic sat_t saturate(input logic signed [23:0] v);
    sat_t r;
    r.ovr = v > 24'sd32767 || v < -24'sd32768;
    r.val = v > 24'sd32767 ? Q_MAX : v < -24'sd32768 ? Q_MIN : v[Q_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/current_sense_frontend_spi_adc_rx.sv
// spi_adc_rx: mode-0 SPI master reading one 16-bit ADC frame per start, done pulses in CALC
module spi_adc_rx
  import current_sense_frontend_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic        idle,
  output logic        done,
  output logic [15:0] data
);
  localparam int CW = $clog2(SCLK_DIV);
  adc_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] half_q, half_d;
  logic sclk_q, sclk_d, cs_n_q, cs_n_d;
  logic [15:0] shift_q, shift_d;
  logic wrap;
  assign wrap = cnt_q == CW'(SCLK_DIV - 1);
  assign sclk = sclk_q;
  assign cs_n = cs_n_q;
  assign idle = state_q == IDLE;
  assign done = state_q == CALC;
  assign data = shift_q;
  // frame sequencing: setup, 32 sclk half-periods sampling on rising edges, hold, one calc cycle
  always_comb begin
    state_d = state_q;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    half_d = half_q;
    sclk_d = sclk_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = CS_SETUP;
      end
      CS_SETUP: if (wrap) begin
        state_d = SHIFT;
        half_d = '0;
      end
      SHIFT: if (wrap) begin
        sclk_d = !sclk_q;
        half_d = half_q + 1'b1;
        if (!sclk_q) shift_d = {shift_q[14:0], miso};
        if (half_q == 5'd31) state_d = CS_HOLD;
      end
      CS_HOLD: if (wrap) state_d = CALC;
      default: state_d = IDLE;
    endcase
    cs_n_d = !(state_d == CS_SETUP || state_d == SHIFT);
  end
  // frame registers; reset drops cs_n and sclk straight to idle levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      half_q <= '0;
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      half_q <= half_d;
      sclk_q <= sclk_d;
      cs_n_q <= cs_n_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/current_sense_frontend.sv
// current_sense_frontend: periodic ADC sampling, offset calibration and Q8.8 current scaling
module current_sense_frontend
  import current_sense_frontend_pkg::*;
#(
  parameter int WL = 16,
  parameter int SCLK_DIV = 4,
  parameter int SAMPLE_DIV = 50000,
  parameter logic [15:0] GAIN = 16'd256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          cal_req,
  input  logic          adc_miso,
  output logic          adc_sclk,
  output logic          adc_cs_n,
  output logic [WL-1:0] current_o,
  output logic          cc_en_o,
  output logic          cal_busy_o,
  output logic          overrange_o
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CCW = $clog2(CAL_SAMPLES);
  logic [TW-1:0] timer_q, timer_d;
  logic pending_q, pending_d, cal_q, cal_d, cc_en_q, cc_en_d, ovr_q, ovr_d;
  logic [CCW-1:0] cal_cnt_q, cal_cnt_d;
  logic signed [15:0] acc_q, acc_d, acc_sum;
  logic signed [11:0] offset_q, offset_d;
  logic [WL-1:0] current_q, current_d;
  logic tick, idle, done, last_cal, unused_hdr;
  logic [15:0] frame;
  logic [11:0] code;
  logic signed [12:0] centered;
  logic signed [13:0] diff;
  logic signed [31:0] prod;
  sat_t sat;
  spi_adc_rx #(.SCLK_DIV(SCLK_DIV)) u_rx (
    .clk(clk), .rst_n(rst_n), .start(tick), .miso(adc_miso),
    .sclk(adc_sclk), .cs_n(adc_cs_n), .idle(idle), .done(done), .data(frame)
  );
  assign code = frame[11:0];
  assign unused_hdr = ^frame[15:12];
  assign tick = enable && timer_q == '0;
  assign cal_busy_o = pending_q || cal_q;
  assign centered = $signed({1'b0, code}) - $signed({1'b0, ADC_MID});
  assign diff = 14'(centered) - 14'(offset_q);
  assign prod = 32'(diff) * $signed({16'b0, GAIN});
  assign sat = saturate(24'(prod >>> 8));
  assign acc_sum = acc_q + 16'(centered);
  assign last_cal = cal_cnt_q == CCW'(CAL_SAMPLES - 1);
  assign current_o = current_q;
  assign cc_en_o = cc_en_q;
  assign overrange_o = ovr_q;
  // sample timer, calibration bookkeeping and scaled output update on frame completion
  always_comb begin
    timer_d = (!enable || timer_q == TW'(SAMPLE_DIV - 1)) ? '0 : timer_q + 1'b1;
    pending_d = pending_q;
    cal_d = cal_q;
    cal_cnt_d = cal_cnt_q;
    acc_d = acc_q;
    offset_d = offset_q;
    current_d = current_q;
    cc_en_d = 1'b0;
    ovr_d = 1'b0;
    if (cal_req && !cal_busy_o) pending_d = 1'b1;
    if (tick && idle && pending_q) begin
      pending_d = 1'b0;
      cal_d = 1'b1;
    end
    if (done && cal_q) begin
      acc_d = last_cal ? '0 : acc_sum;
      cal_cnt_d = last_cal ? '0 : cal_cnt_q + 1'b1;
      cal_d = !last_cal;
      offset_d = last_cal ? 12'(acc_sum >>> 4) : offset_q;
    end
    if (done && !cal_q) begin
      current_d = WL'($signed(sat.val));
      cc_en_d = 1'b1;
      ovr_d = sat.ovr;
    end
  end
  // state registers, cleared asynchronously so a reset also discards any calibration in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      pending_q <= 1'b0;
      cal_q <= 1'b0;
      cal_cnt_q <= '0;
      acc_q <= '0;
      offset_q <= '0;
      current_q <= '0;
      cc_en_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pending_q <= pending_d;
      cal_q <= cal_d;
      cal_cnt_q <= cal_cnt_d;
      acc_q <= acc_d;
      offset_q <= offset_d;
      current_q <= current_d;
      cc_en_q <= cc_en_d;
      ovr_q <= ovr_d;
    end
  end
endmodule

// File: tb/tb_current_sense_frontend.sv
// tb_current_sense_frontend: directed checks of two lockstep instances (GAIN 1.0 and 32.0) against a serial ADC model
module tb_current_sense_frontend;
  localparam int SD = 4;
  localparam int LAT = 34 * SD + 2;
  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, cal_req = 1'b0, adc_miso = 1'b0;
  logic sclk0, cs_n0, cc0, busy0, ovr0, sclk1, cs_n1, cc1, busy1, ovr1;
  logic [15:0] cur0, cur1;
  logic [11:0] adc_code = 12'd0;
  logic [15:0] adc_word;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  int bit_idx = 0, rise_cnt = 0, vectors = 0, errors = 0;
  time last_rise = 0, period = 0;

  current_sense_frontend #(.WL(16), .SCLK_DIV(SD), .SAMPLE_DIV(200), .GAIN(16'd256)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cal_req(cal_req), .adc_miso(adc_miso),
    .adc_sclk(sclk0), .adc_cs_n(cs_n0), .current_o(cur0), .cc_en_o(cc0),
    .cal_busy_o(busy0), .overrange_o(ovr0));
  current_sense_frontend #(.WL(16), .SCLK_DIV(SD), .SAMPLE_DIV(200), .GAIN(16'd8192)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cal_req(cal_req), .adc_miso(adc_miso),
    .adc_sclk(sclk1), .adc_cs_n(cs_n1), .current_o(cur1), .cc_en_o(cc1),
    .cal_busy_o(busy1), .overrange_o(ovr1));

  always #5 clk = ~clk;
  assign adc_word = {4'hA, adc_code};

  // ADC model: MSB on cs_n fall, next bit after each sclk fall; also measures sclk rises and period
  always @(negedge clk) begin
    if (prev_cs && !cs_n0) begin
      bit_idx = 15;
      rise_cnt = 0;
      last_rise = 0;
    end else if (prev_sclk && !sclk0 && bit_idx > 0) bit_idx--;
    if (!prev_sclk && sclk0) begin
      if (last_rise != 0) period = $time - last_rise;
      last_rise = $time;
      rise_cnt++;
    end
    adc_miso = adc_word[bit_idx];
    prev_cs = cs_n0;
    prev_sclk = sclk0;
  end

  task automatic run_frame(input logic [11:0] code, output int n_seen, output int pulses,
                           output logic o0, output logic o1, output logic c1);
    adc_code = code;
    n_seen = -1;
    pulses = 0;
    o0 = 1'bx;
    o1 = 1'bx;
    c1 = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) enable = 1'b0;
      if (cc0) pulses++;
      if (cc0 && n_seen < 0) begin
        n_seen = n;
        o0 = ovr0;
        o1 = ovr1;
        c1 = cc1;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (cs_n0 !== 1'b1 || cs_n1 !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b/%b want 1/1", cs_n0, cs_n1); end
    vectors++; if (sclk0 !== 1'b0 || sclk1 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b/%b want 0/0", sclk0, sclk1); end
    vectors++; if (cur0 !== 16'd0 || cur1 !== 16'd0) begin errors++; $display("FAIL reset_current: got %h/%h want 0", cur0, cur1); end
    vectors++; if (cc0 !== 1'b0 || ovr0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_flags: cc %b ovr %b busy %b want 0", cc0, ovr0, busy0); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (cs_n0 !== 1'b1 || cc0 !== 1'b0) begin errors++; $display("FAIL idle_disabled: cs_n %b cc %b want 1 0", cs_n0, cc0); end
  endtask

  task automatic test_single_frame;
    int n, p;
    logic o0, o1, c1;
    run_frame(12'd2304, n, p, o0, o1, c1);
    vectors++; if (n !== LAT) begin errors++; $display("FAIL latency: got %0d want %0d", n, LAT); end
    vectors++; if (p !== 1) begin errors++; $display("FAIL cc_en_pulses: got %0d want 1", p); end
    vectors++; if (cur0 !== 16'd256 || o0 !== 1'b0) begin errors++; $display("FAIL unity_gain: got %0d ovr %b want 256 ovr 0", $signed(cur0), o0); end
    vectors++; if (cur1 !== 16'd8192 || o1 !== 1'b0 || c1 !== 1'b1) begin errors++; $display("FAIL high_gain: got %0d ovr %b cc %b want 8192 0 1", $signed(cur1), o1, c1); end
    vectors++; if (rise_cnt !== 16) begin errors++; $display("FAIL sclk_rises: got %0d want 16", rise_cnt); end
    vectors++; if (period !== 80) begin errors++; $display("FAIL sclk_period: got %0t want 80", period); end
    vectors++; if (cs_n0 !== 1'b1 || sclk0 !== 1'b0) begin errors++; $display("FAIL post_frame_idle: cs_n %b sclk %b want 1 0", cs_n0, sclk0); end
  endtask

  task automatic test_saturation;
    logic [11:0] codes[6] = '{12'd4095, 12'd0, 12'd2048, 12'd1000, 12'd3071, 12'd3072};
    logic [15:0] e0[6] = '{16'h07FF, 16'hF800, 16'h0000, 16'hFBE8, 16'h03FF, 16'h0400};
    logic [15:0] e1[6] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h7FE0, 16'h7FFF};
    logic v1[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int n, p;
    logic o0, o1, c1;
    for (int i = 0; i < 6; i++) begin
      run_frame(codes[i], n, p, o0, o1, c1);
      vectors++; if (cur0 !== e0[i] || o0 !== 1'b0) begin errors++; $display("FAIL sat_g1 code %0d: got %h ovr %b want %h ovr 0", codes[i], cur0, o0, e0[i]); end
      vectors++; if (cur1 !== e1[i] || o1 !== v1[i]) begin errors++; $display("FAIL sat_g32 code %0d: got %h ovr %b want %h ovr %b", codes[i], cur1, o1, e1[i], v1[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int first = -1, second = -1, cnt = 0;
    adc_code = 12'd2304;
    @(negedge clk);
    enable = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (cc0) begin
        cnt++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      if (n == 40) enable = 1'b0;
      if (n == 41) enable = 1'b1;
      if (n == 400) enable = 1'b0;
    end
    vectors++; if (first !== LAT) begin errors++; $display("FAIL drop_first: got %0d want %0d", first, LAT); end
    vectors++; if (second !== 241 + LAT) begin errors++; $display("FAIL drop_second: got %0d want %0d", second, 241 + LAT); end
    vectors++; if (cnt !== 2) begin errors++; $display("FAIL drop_count: got %0d want 2", cnt); end
  endtask

  task automatic test_calibration;
    int ccs = 0, fall = -1, n, p;
    logic o0, o1, c1;
    @(negedge clk);
    cal_req = 1'b1;
    @(negedge clk);
    cal_req = 1'b0;
    vectors++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL cal_busy_rise: got %b/%b want 1/1", busy0, busy1); end
    adc_code = 12'd2058;
    enable = 1'b1;
    for (int i = 1; i <= 3300; i++) begin
      @(negedge clk);
      if (cc0 || cc1) ccs++;
      if (!busy0 && fall < 0) fall = i;
      if (i == 500) cal_req = 1'b1;
      if (i == 501) cal_req = 1'b0;
      if (i == 3150) enable = 1'b0;
    end
    vectors++; if (ccs !== 0) begin errors++; $display("FAIL cal_no_cc_en: got %0d pulses want 0", ccs); end
    vectors++; if (fall !== 3000 + LAT) begin errors++; $display("FAIL cal_busy_fall: got %0d want %0d", fall, 3000 + LAT); end
    vectors++; if (cur0 !== 16'd256 || cur1 !== 16'd8192) begin errors++; $display("FAIL cal_hold_current: got %h/%h want 0100/2000", cur0, cur1); end
    run_frame(12'd2058, n, p, o0, o1, c1);
    vectors++; if (n !== LAT || cur0 !== 16'd0 || cur1 !== 16'd0) begin errors++; $display("FAIL cal_offset_zero: n %0d got %h/%h want %0d 0/0", n, cur0, cur1, LAT); end
    run_frame(12'd2304, n, p, o0, o1, c1);
    vectors++; if (cur0 !== 16'd246 || cur1 !== 16'd7872) begin errors++; $display("FAIL cal_offset_applied: got %0d/%0d want 246/7872", $signed(cur0), $signed(cur1)); end
  endtask

  task automatic test_reset_mid_frame;
    int cnt = 0, n, p;
    logic o0, o1, c1;
    adc_code = 12'd2304;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 1) enable = 1'b0;
    end
    vectors++; if (cs_n0 !== 1'b0) begin errors++; $display("FAIL mid_frame_active: cs_n %b want 0", cs_n0); end
    rst_n = 1'b0;
    #1;
    vectors++; if (cs_n0 !== 1'b1 || sclk0 !== 1'b0 || sclk1 !== 1'b0) begin errors++; $display("FAIL abort_spi: cs_n %b sclk %b/%b want 1 0/0", cs_n0, sclk0, sclk1); end
    vectors++; if (cur0 !== 16'd0 || cur1 !== 16'd0 || cc0 !== 1'b0 || ovr0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL abort_outputs: cur %h/%h cc %b ovr %b busy %b want 0", cur0, cur1, cc0, ovr0, busy0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cc0) cnt++;
    end
    vectors++; if (cnt !== 0) begin errors++; $display("FAIL no_cc_after_reset: got %0d want 0", cnt); end
    run_frame(12'd2058, n, p, o0, o1, c1);
    vectors++; if (n !== LAT || cur0 !== 16'd10 || cur1 !== 16'd320) begin errors++; $display("FAIL offset_cleared: n %0d got %0d/%0d want %0d 10/320", n, $signed(cur0), $signed(cur1), LAT); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_saturation();
    test_back_to_back();
    test_calibration();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/current_sense_frontend.md
CURRENT_SENSE_FRONTEND -- requirements
Module: current_sense_frontend

Interface
REQ-001 Parameter WL, default 16, current word width (Q8.8 signed).
REQ-002 Parameter SCLK_DIV, default 4, clk cycles per adc_sclk half-period (>=2).
REQ-003 Parameter SAMPLE_DIV, default 50000, clk cycles between sample starts (> 40*SCLK_DIV).
REQ-004 Parameter GAIN, default 16'd256, unsigned Q8.8 scale from ADC LSB to current LSB.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  level; 1 = periodic sampling runs.
REQ-008 cal_req  in  1  one-cycle pulse; request zero-current offset calibration.
REQ-009 adc_miso  in  1  serial data from 12-bit ADC, MSB first.
REQ-010 adc_sclk  out  1  SPI clock, mode 0, idles low.
REQ-011 adc_cs_n  out  1  ADC chip select, active-low.
REQ-012 current_o  out  WL  signed Q8.8 current, held between updates; feeds coulomb counter current_i.
REQ-013 cc_en_o  out  1  one-cycle strobe, current_o newly valid; feeds counter cc_en.
REQ-014 cal_busy_o  out  1  high while calibration in progress.
REQ-015 overrange_o  out  1  high with cc_en_o when the sample saturated.

Function
REQ-016 Sample timer counts 0..SAMPLE_DIV-1 while enable=1, wraps, and issues a start tick at 0; held at 0 while enable=0.
REQ-017 FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD, CALC; IDLE->CS_SETUP on tick.
REQ-018 CS_SETUP: adc_cs_n low for SCLK_DIV cycles, sclk low, then SHIFT.
REQ-019 SHIFT: 16 sclk periods; adc_miso sampled on each sclk rising edge into 16-bit shift register; after 16th falling edge -> CS_HOLD.
REQ-020 CS_HOLD: adc_cs_n high for SCLK_DIV cycles, then CALC; code = shift[11:0], shift[15:12] ignored.
REQ-021 CALC (one cycle): diff = code - 2048 - offset (14-bit signed); prod = diff * GAIN (GAIN zero-extended); cur = prod >>> 8; saturate to [-32768, 32767].
REQ-022 Normal mode: in CALC+1 cycle current_o updated, cc_en_o=1 for exactly one cycle, overrange_o=1 iff saturated; return to IDLE.
REQ-023 Latency tick -> cc_en_o: 2*SCLK_DIV + 32*SCLK_DIV + 2 cycles, fixed.
REQ-024 Ticks arriving while FSM not in IDLE are discarded.
REQ-025 enable deasserted mid-frame: current frame completes (including cc_en_o); no further frames.
REQ-026 cal_req latched into pending flag at any time; cal starts at next tick (cal_busy_o rises the cycle after latch); cal_req while cal_busy_o=1 ignored.
REQ-027 Calibration: next 16 frames accumulate (code - 2048) into signed 16-bit acc; after 16th, offset = acc >>> 4 (arithmetic), cal_busy_o low same cycle.
REQ-028 During calibration cc_en_o stays 0 and current_o holds its value.
REQ-029 Offset is 12-bit signed, applied to all subsequent samples; calibration never modifies GAIN.

Reset
REQ-030 On rst_n low: FSM IDLE, adc_cs_n=1, adc_sclk=0, current_o=0, cc_en_o=0, overrange_o=0, cal_busy_o=0, offset=0, timer=0, pending cleared.
REQ-031 Reset mid-frame aborts SPI immediately (cs_n high, sclk low same cycle); mid-calibration discards acc and keeps offset=0.

Structure
REQ-032 Shared bms package holds Q8.8 width, Q8.8 min/max saturation constants, ADC midscale 2048, calibration sample count 16.
REQ-033 One sub-module: spi_adc_rx (mode-0 SPI master, 16-bit frame, start/done handshake); scaling, calibration and timer stay in the top.

Verification
REQ-034 GAIN=256, offset 0, ADC returns 12'd2304 -> current_o=16'sd256 (1.0 A), one cc_en_o pulse, overrange_o=0.
REQ-035 GAIN=8192, code 4095 -> current_o=16'sd32767, overrange_o=1; code 0 -> current_o=-32768, overrange_o=1.
REQ-036 cal_req, ADC returns 2058 for 16 frames -> cal_busy_o high 16 frames, no cc_en_o; then offset=10, code 2058 -> current_o=0.
REQ-037 Check adc_sclk period = 2*SCLK_DIV, 16 rising edges per cs_n low window, cc_en_o at REQ-023 latency; ticks during frame dropped.
REQ-038 rst_n low in SHIFT bit 7 -> cs_n=1, sclk=0 immediately; after release no cc_en_o until next full frame; outputs at REQ-030 values.
